ifetch_unit: RTL and testbench
==============================

# ifetch_unit

Instruction fetch front-end for the single-issue MIPS core. Owns the fetch PC, drives the word address into the instruction memory, captures the combinationally returned instruction word into a 2-entry fetch queue, and presents it to decode over a valid/ready handshake. Branch and jump resolution redirects fetch and flushes any queued, wrong-path instructions.

## Interface
- ADDR_W, 32: fetch address width; matches the instruction memory address port.
- RESET_PC, 0: word index loaded into the fetch PC at reset.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- imem_pc  out  ADDR_W  word index to instruction memory (word index, not byte address)
- imem_instr  in  32  instruction word returned combinationally for imem_pc
- fetch_en  in  1  1 = fetch allowed; 0 = hold PC, no enqueue (pipeline halt)
- redirect_valid  in  1  branch/jump taken; single-cycle pulse
- redirect_pc  in  ADDR_W  target word index
- out_valid  out  1  head of queue holds a valid instruction
- out_ready  in  1  decode accepts head this cycle
- out_instr  out  32  head instruction word
- out_pc  out  ADDR_W  word index of head instruction
- q_count  out  2  queue occupancy, 0..2

## Operation
- State: fetch_pc register, 2-entry queue (instr + pc per entry), head pointer, count.
- imem_pc = fetch_pc (direct register output, no combinational path from inputs).
- pop = out_valid & out_ready.
- push = fetch_en & ~redirect_valid & (count < 2 | pop).
- On push: enqueue {imem_instr, fetch_pc} at tail; fetch_pc <= fetch_pc + 1 (mod 2^ADDR_W, wraps silently).
- Simultaneous push and pop at count 2: legal; count stays 2, head advances.
- Simultaneous push and pop at count 1: count stays 1; new entry becomes head next cycle.
- Pop with count 0: impossible (out_valid = 0); out_ready ignored.
- redirect_valid (highest priority): queue flushed (count <= 0), fetch_pc <= redirect_pc, no push, any pop that cycle is discarded as well (head already consumed by decode is decode's responsibility). fetch_en ignored that cycle.
- fetch_en = 0 with no redirect: fetch_pc holds, pop still operates, queue drains.
- out_instr/out_pc valid only when out_valid = 1; they are the stored head entry and hold stable while out_valid & ~out_ready.
- Entries reading zero-filled memory are enqueued unchanged (0x00000000 = nop); no special handling.

## Timing
- Reset (async assert, sync-safe release): fetch_pc = RESET_PC, count = 0, head = 0, all queue entries = 0; outputs: imem_pc = RESET_PC, out_valid = 0, out_instr = 0, out_pc = 0, q_count = 0.
- Reset asserted mid-operation: all state returns to reset values immediately; queued instructions lost.
- Fetch latency: instruction at word N enqueued at the edge where imem_pc = N and push = 1; out_valid high from the following cycle (1-cycle fetch-to-decode latency).
- Steady state with out_ready = 1: one instruction per cycle, out_pc increments by 1 per cycle.
- Redirect at edge E: after E, count = 0, imem_pc = redirect_pc; target instruction on out_* after edge E+1 (1-cycle bubble).
- Backpressure: out_ready = 0 for ≥2 cycles fills queue; fetch_pc stops advancing while count = 2 and no pop.

## Configuration
- IFETCH_STATS_EN defined: adds output port fetch_count (32 bits), reset to 0, incremented on every pop not coincident with redirect_valid, cleared by redirect? No — never cleared except by reset; wraps at 2^32.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Reset, RESET_PC = 0, fetch_en = 1, out_ready = 1, memory word k = 0x1000_0000 + k -> out_valid rises 1 cycle after reset release; out_pc = 0,1,2,3 with out_instr = 0x10000000..0x10000003 on consecutive cycles.
- out_ready = 0 for 4 cycles after first valid -> q_count reaches 2, imem_pc frozen at 2, out_pc/out_instr held at 0/0x10000000; releasing out_ready delivers 0,1,2 without gaps or duplicates.
- Redirect pulse with redirect_pc = 0x20 while q_count = 2 -> next cycle q_count = 0, out_valid = 0, imem_pc = 0x20; following cycle out_pc = 0x20, out_instr = word 0x20.
- redirect_valid and out_ready and fetch_en all high at count 2 -> redirect wins: queue empty, no enqueue, fetch_pc = redirect_pc.
- fetch_en = 0 for 3 cycles, out_ready = 1 -> queue drains to 0, imem_pc unchanged, out_valid low; re-enable resumes at held PC.
- Assert rst_n low asynchronously between edges during streaming -> outputs immediately 0/RESET_PC; with IFETCH_STATS_EN, fetch_count = 0 after reset and equals number of accepted instructions (e.g. 5 after 5 pops).

Source files
------------

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - Instruction fetch front-end: fetch PC, 2-entry fetch queue, redirect flush.
// Optional macro IFETCH_STATS_EN adds the fetch_count accepted-instruction counter port.
module ifetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_pc,
  input  logic [31:0]       imem_instr,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic [1:0]        q_count
`ifdef IFETCH_STATS_EN
  ,
  output logic [31:0]       fetch_count
`endif
);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [31:0]       instr_q [2];
  logic [ADDR_W-1:0] pc_q    [2];
  logic              head_q, head_d;
  logic [1:0]        count_q, count_d;
  logic              pop, push, tail;

  assign imem_pc   = fetch_pc_q;
  assign out_valid = (count_q != 2'd0);
  assign out_instr = instr_q[head_q];
  assign out_pc    = pc_q[head_q];
  assign q_count   = count_q;

  assign pop  = out_valid & out_ready;
  assign push = fetch_en & ~redirect_valid & ((count_q != 2'd2) | pop);
  // Tail slot is (head + count) mod 2; at count 2 with a pop it reuses the slot being vacated.
  assign tail = head_q ^ count_q[0];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    count_d    = count_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      count_d    = 2'd0;
    end else begin
      if (pop) begin
        head_d = ~head_q;
      end
      if (push) begin
        fetch_pc_d = fetch_pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      head_q     <= 1'b0;
      count_q    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        instr_q[i] <= 32'd0;
        pc_q[i]    <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      count_q    <= count_d;
      if (push) begin
        instr_q[tail] <= imem_instr;
        pc_q[tail]    <= fetch_pc_q;
      end
    end
  end

`ifdef IFETCH_STATS_EN
  logic [31:0] fetch_count_q;

  assign fetch_count = fetch_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_q <= 32'd0;
    end else if (pop && !redirect_valid) begin
      fetch_count_q <= fetch_count_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - Randomized self-checking bench for ifetch_unit against a queue-level model.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_pc, imem_instr, redirect_pc, out_instr, out_pc;
  logic        fetch_en, redirect_valid, out_valid, out_ready;
  logic [1:0]  q_count;
`ifdef IFETCH_STATS_EN
  logic [31:0] fetch_count;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] m_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_stats;
  logic [31:0] held;

  ifetch_unit #(.ADDR_W(32), .RESET_PC(32'd0)) dut (
    .clk(clk), .rst_n(rst_n), .imem_pc(imem_pc), .imem_instr(imem_instr),
    .fetch_en(fetch_en), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .q_count(q_count)
`ifdef IFETCH_STATS_EN
    , .fetch_count(fetch_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'h1000_0000 + a;
  endfunction

  assign imem_instr = mem(imem_pc);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc    = 32'd0;
    m_stats = 32'd0;
  endtask

  task automatic model_step();
    bit pop, push;
    pop  = (m_q.size() > 0) && out_ready;
    push = fetch_en && !redirect_valid && ((m_q.size() < 2) || pop);
    if (redirect_valid) begin
      m_q.delete();
      m_pc = redirect_pc;
    end else begin
      if (pop) begin
        void'(m_q.pop_front());
        m_stats++;
      end
      if (push) begin
        m_q.push_back(m_pc);
        m_pc++;
      end
    end
  endtask

  task automatic check_all();
    chk("imem_pc", imem_pc, m_pc);
    chk("out_valid", {31'd0, out_valid}, (m_q.size() > 0) ? 32'd1 : 32'd0);
    chk("q_count", {30'd0, q_count}, m_q.size());
    if (m_q.size() > 0) begin
      chk("out_pc", out_pc, m_q[0]);
      chk("out_instr", out_instr, mem(m_q[0]));
    end
`ifdef IFETCH_STATS_EN
    chk("fetch_count", fetch_count, m_stats);
`endif
  endtask

  // Inputs are set at the negedge; the DUT and the model both consume them at the posedge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    redirect_valid = 1'b0;
    check_all();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_imem_pc"}, imem_pc, 32'd0);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_q_count"}, {30'd0, q_count}, 32'd0);
    chk({tag, "_out_instr"}, out_instr, 32'd0);
    chk({tag, "_out_pc"}, out_pc, 32'd0);
`ifdef IFETCH_STATS_EN
    chk({tag, "_fetch_count"}, fetch_count, 32'd0);
`endif
  endtask

  initial begin
    rst_n = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'd0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Streaming: out_pc 0..3 on consecutive cycles.
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("stream_pc", out_pc, k);
      chk("stream_instr", out_instr, 32'h1000_0000 + k);
    end

    // Backpressure fills the queue and freezes the fetch PC.
    out_ready = 1'b0;
    repeat (4) cycle();
    chk("bp_count", {30'd0, q_count}, 32'd2);
    chk("bp_imem_pc", imem_pc, 32'd5);
    chk("bp_out_pc", out_pc, 32'd3);
    chk("bp_out_instr", out_instr, 32'h1000_0003);
    out_ready = 1'b1;
    for (int k = 4; k < 7; k++) begin
      cycle();
      chk("drain_pc", out_pc, k);
    end

    // Redirect with ready and fetch_en also high at count 2.
    out_ready = 1'b0;
    repeat (2) cycle();
    chk("pre_redir_count", {30'd0, q_count}, 32'd2);
    redirect_valid = 1'b1; redirect_pc = 32'h20; out_ready = 1'b1;
    cycle();
    chk("redir_count", {30'd0, q_count}, 32'd0);
    chk("redir_valid", {31'd0, out_valid}, 32'd0);
    chk("redir_imem_pc", imem_pc, 32'h20);
    cycle();
    chk("target_pc", out_pc, 32'h20);
    chk("target_instr", out_instr, 32'h1000_0020);

    // Halt: queue drains, PC held, resume at held PC.
    held = m_pc;
    fetch_en = 1'b0;
    repeat (3) cycle();
    chk("halt_count", {30'd0, q_count}, 32'd0);
    chk("halt_valid", {31'd0, out_valid}, 32'd0);
    chk("halt_imem_pc", imem_pc, held);
    fetch_en = 1'b1;
    cycle();
    chk("resume_pc", out_pc, held);

    // Randomized traffic, including redirects near the address wrap.
    for (int n = 0; n < 600; n++) begin
      fetch_en       = ($urandom_range(0, 3) != 0);
      out_ready      = ($urandom_range(0, 9) < 6);
      redirect_valid = ($urandom_range(0, 99) < 8);
      redirect_pc    = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFE : $urandom;
      cycle();
    end

    // Asynchronous reset between edges during streaming.
    fetch_en = 1'b1; out_ready = 1'b1;
    repeat (3) cycle();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) cycle();
`ifdef IFETCH_STATS_EN
    chk("stats_five", fetch_count, 32'd5);
`endif
    chk("post_reset_pc", out_pc, 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
